// File: rtl/test_earth_rx.sv
// Ethernet UDP loopback RX checker: drains the RX FIFO, locks to "Just for earthnet test!\r", counts good/bad words.
// Latency: erd_en is combinational; status updates on the edge that ends the rd_vld cycle (2 clk after erd_en).
// Backpressure: none; reads at full rate whenever en=1 and the FIFO is non-empty; gaps only pause checking.
// Optional capture of the first bad word and its index: define TEST_EARTH_RX_CAPTURE_EN.
module test_earth_rx #(
  parameter int GOOD_CNT_W = 32,
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_CNT   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  erx_empty,
  input  logic [63:0]           erx_dout,
  output logic                  erd_en,
  output logic                  locked,
  output logic                  err_flag,
  output logic [GOOD_CNT_W-1:0] good_cnt,
  output logic [ERR_CNT_W-1:0]  err_cnt
`ifdef TEST_EARTH_RX_CAPTURE_EN
  ,
  output logic [63:0]           bad_word,
  output logic [1:0]            bad_idx
`endif
);

  localparam logic [63:0] PAT0 = 64'h4a75737420666f72;  // "Just for"
  localparam logic [63:0] PAT1 = 64'h2065617274686e65;  // " earthne"
  localparam logic [63:0] PAT2 = 64'h742074657374210d;  // "t test!\r"
  localparam logic [7:0]  LOCK_V   = 8'(LOCK_CNT);
  localparam logic [GOOD_CNT_W-1:0] GOOD_ONE = 1;
  localparam logic [ERR_CNT_W-1:0]  ERR_ONE  = 1;

  typedef enum logic {HUNT, TRACK} state_t;

  state_t      state;
  logic        rd_vld;
  logic        en_q;
  logic [1:0]  j;
  logic [7:0]  run;
  logic [63:0] exp_word;
  logic        chk;
  logic        hit;
  logic        is_p0;
  logic        en_rise;
  logic [7:0]  run_inc;
  logic [ERR_CNT_W-1:0] err_inc;

  // Read strobe: full rate while enabled; held off during reset so nothing is drained blind.
  assign erd_en  = en & ~erx_empty & rst_n;
  assign en_rise = en & ~en_q;
  // A word returned after en dropped is discarded unchecked.
  assign chk     = rd_vld & en;
  assign hit     = (erx_dout == exp_word);
  assign is_p0   = (erx_dout == PAT0);
  assign run_inc = (run >= LOCK_V) ? LOCK_V : run + 8'd1;
  assign err_inc = (&err_cnt) ? err_cnt : err_cnt + ERR_ONE;

  // Expected word for the current pattern index.
  always_comb begin
    exp_word = PAT0;
    case (j)
      2'd1:    exp_word = PAT1;
      2'd2:    exp_word = PAT2;
      default: exp_word = PAT0;
    endcase
  end

  // Lock/track state machine with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      rd_vld   <= 1'b0;
      en_q     <= 1'b0;
      j        <= 2'd0;
      run      <= 8'd0;
      locked   <= 1'b0;
      err_flag <= 1'b0;
      good_cnt <= '0;
      err_cnt  <= '0;
`ifdef TEST_EARTH_RX_CAPTURE_EN
      bad_word <= 64'd0;
      bad_idx  <= 2'd0;
`endif
    end else begin
      en_q   <= en;
      rd_vld <= erd_en;
      if (!en) begin
        state  <= HUNT;
        j      <= 2'd0;
        run    <= 8'd0;
        locked <= 1'b0;
      end else begin
        if (en_rise) begin
          good_cnt <= '0;
          err_cnt  <= '0;
          err_flag <= 1'b0;
`ifdef TEST_EARTH_RX_CAPTURE_EN
          bad_word <= 64'd0;
          bad_idx  <= 2'd0;
`endif
        end
        if (chk) begin
          case (state)
            HUNT: begin
              // Anything other than the frame start is ignored while hunting.
              if (is_p0) begin
                j        <= 2'd1;
                run      <= 8'd1;
                good_cnt <= good_cnt + GOOD_ONE;
                locked   <= (LOCK_V == 8'd1);
                state    <= TRACK;
              end
            end
            default: begin
              if (hit) begin
                good_cnt <= good_cnt + GOOD_ONE;
                j        <= (j == 2'd2) ? 2'd0 : j + 2'd1;
                run      <= run_inc;
                if (run_inc == LOCK_V) locked <= 1'b1;
              end else begin
                err_cnt  <= err_inc;
                err_flag <= 1'b1;
                locked   <= 1'b0;
`ifdef TEST_EARTH_RX_CAPTURE_EN
                if (!err_flag) begin
                  bad_word <= erx_dout;
                  bad_idx  <= j;
                end
`endif
                if (is_p0) begin
                  // The bad word is itself a frame start: resync without hunting.
                  j        <= 2'd1;
                  run      <= 8'd1;
                  good_cnt <= good_cnt + GOOD_ONE;
                end else begin
                  j     <= 2'd0;
                  run   <= 8'd0;
                  state <= HUNT;
                end
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_test_earth_rx.sv
// Bench for test_earth_rx: FIFO model feeding words, expected status queued per word and compared 2 clk after the read.
// A second instance with a 2-bit error counter shares the stimulus to show saturation.
module tb_test_earth_rx;

  localparam logic [63:0] P0 = 64'h4a75737420666f72;
  localparam logic [63:0] P1 = 64'h2065617274686e65;
  localparam logic [63:0] P2 = 64'h742074657374210d;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        erx_empty;
  logic [63:0] erx_dout;
  logic        erd_en, locked, err_flag;
  logic [31:0] good_cnt;
  logic [15:0] err_cnt;
  logic        s_erd_en, s_locked, s_err_flag;
  logic [31:0] s_good_cnt;
  logic [1:0]  s_err_cnt;
`ifdef TEST_EARTH_RX_CAPTURE_EN
  logic [63:0] bad_word, s_bad_word;
  logic [1:0]  bad_idx, s_bad_idx;
`endif

  always #5 clk = ~clk;

  test_earth_rx #(.GOOD_CNT_W(32), .ERR_CNT_W(16), .LOCK_CNT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .erx_empty(erx_empty), .erx_dout(erx_dout),
    .erd_en(erd_en), .locked(locked), .err_flag(err_flag), .good_cnt(good_cnt), .err_cnt(err_cnt)
`ifdef TEST_EARTH_RX_CAPTURE_EN
    , .bad_word(bad_word), .bad_idx(bad_idx)
`endif
  );

  test_earth_rx #(.GOOD_CNT_W(32), .ERR_CNT_W(2), .LOCK_CNT(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .erx_empty(erx_empty), .erx_dout(erx_dout),
    .erd_en(s_erd_en), .locked(s_locked), .err_flag(s_err_flag), .good_cnt(s_good_cnt), .err_cnt(s_err_cnt)
`ifdef TEST_EARTH_RX_CAPTURE_EN
    , .bad_word(s_bad_word), .bad_idx(s_bad_idx)
`endif
  );

  typedef struct {
    bit          restart;
    int          gap;
    logic [63:0] w;
    int          g;
    int          e;
    bit          f;
    bit          l;
  } row_t;

  typedef struct {
    int id;
    int g;
    int e;
    bit f;
    bit l;
  } exp_t;

  row_t        tbl[$];
  exp_t        sb[$];
  logic [63:0] fifo[$];
  bit          due1, due2;
  int          total, bad, pulses, next_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int g, input int e, input bit f, input bit l);
    exp_t x;
    x.id = next_id; x.g = g; x.e = e; x.f = f; x.l = l;
    next_id++;
    return x;
  endfunction

  // One clock: compare due status at negedge, sample erd_en, then serve the FIFO read after the edge.
  task automatic cyc();
    logic rd;
    exp_t x;
    @(negedge clk);
    if (due2) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        x = sb.pop_front();
        chk($sformatf("word%0d {good,err,flag,locked}", x.id),
            {14'd0, good_cnt, err_cnt, err_flag, locked},
            {14'd0, 32'(x.g), 16'(x.e), x.f, x.l});
      end
    end
    rd = erd_en;
    if (rd) pulses++;
    @(posedge clk);
    #1;
    due2 = due1;
    due1 = rd;
    if (rd) begin
      chk("read_while_nonempty", 64'(fifo.size() > 0), 64'd1);
      if (fifo.size() > 0) erx_dout = fifo.pop_front();
    end
    erx_empty = (fifo.size() == 0);
  endtask

  task automatic feed(input logic [63:0] w, input exp_t x);
    fifo.push_back(w);
    sb.push_back(x);
    erx_empty = 1'b0;
    cyc();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((due1 || due2 || fifo.size() > 0) && n < 50) begin
      cyc();
      n++;
    end
    chk("drain_budget", 64'(n < 50), 64'd1);
  endtask

  task automatic restart();
    drain();
    en = 1'b0;
    cyc();
    en = 1'b1;
  endtask

  task automatic add(input bit r, input int gap, input logic [63:0] w,
                     input int g, input int e, input bit f, input bit l);
    row_t t;
    t.restart = r; t.gap = gap; t.w = w; t.g = g; t.e = e; t.f = f; t.l = l;
    tbl.push_back(t);
  endtask

  initial begin
    total = 0; bad = 0; pulses = 0; next_id = 0;
    due1 = 0; due2 = 0;
    rst_n = 1'b0; en = 1'b1; erx_empty = 1'b0; erx_dout = 64'd0;

    // T1: clean stream with a 2-cycle gap; lock 2 clk after the 3rd read
    add(1, 0, P0, 1, 0, 0, 0);  add(0, 0, P1, 2, 0, 0, 0);  add(0, 0, P2, 3, 0, 0, 1);
    add(0, 0, P0, 4, 0, 0, 1);  add(0, 2, P1, 5, 0, 0, 1);  add(0, 0, P2, 6, 0, 0, 1);
    // T2: leading garbage is dropped silently
    add(1, 0, 64'd0, 0, 0, 0, 0);  add(0, 0, 64'd0, 0, 0, 0, 0);
    add(0, 0, P0, 1, 0, 0, 0);  add(0, 0, P1, 2, 0, 0, 0);  add(0, 0, P2, 3, 0, 0, 1);
    // T4: PAT0 where PAT2 expected -> one error and immediate resync
    add(1, 0, P0, 1, 0, 0, 0);  add(0, 0, P1, 2, 0, 0, 0);  add(0, 0, P0, 3, 1, 1, 0);
    add(0, 0, P1, 4, 1, 1, 0);  add(0, 0, P2, 5, 1, 1, 1);
    // T3: corrupted PAT1 -> back to HUNT, PAT2 dropped, relock
    add(1, 0, P0, 1, 0, 0, 0);  add(0, 0, P1 ^ 64'd1, 1, 1, 1, 0);  add(0, 0, P2, 1, 1, 1, 0);
    add(0, 0, P0, 2, 1, 1, 0);  add(0, 0, P1, 3, 1, 1, 0);  add(0, 0, P2, 4, 1, 1, 1);

    // Reset state, with en high and data present to show no reads during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_erd_en", 64'(erd_en), 64'd0);
    chk("rst_status", {14'd0, good_cnt, err_cnt, err_flag, locked}, 64'd0);
    chk("rst_sat_status", {28'd0, s_good_cnt, s_err_cnt, s_err_flag, s_locked}, 64'd0);
    en = 1'b0; erx_empty = 1'b1;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven part
    pulses = 0;
    foreach (tbl[i]) begin
      if (tbl[i].restart) restart();
      for (int k = 0; k < tbl[i].gap; k++) cyc();
      feed(tbl[i].w, mk(tbl[i].g, tbl[i].e, tbl[i].f, tbl[i].l));
    end
    drain();
    chk("read_pulses", 64'(pulses), 64'(tbl.size()));
`ifdef TEST_EARTH_RX_CAPTURE_EN
    chk("bad_word", bad_word, P1 ^ 64'd1);
    chk("bad_idx", 64'(bad_idx), 64'd1);
`endif

    // T5: drop en while a word is in flight; counters hold; re-raise clears
    restart();
    feed(P0, mk(1, 0, 0, 0));
    feed(P2, mk(1, 1, 1, 0));
    feed(P0, mk(2, 1, 1, 0));
    feed(P1, mk(0, 0, 0, 0));   // read issued; en drops before it is checked
    en = 1'b0;
    void'(sb.pop_back());
    due1 = 1'b0;
    fifo.push_back(P0);
    sb.push_back(mk(1, 0, 0, 0));
    erx_empty = 1'b0;
    repeat (3) cyc();
    chk("en0_erd_en", 64'(erd_en), 64'd0);
    chk("en0_hold", {14'd0, good_cnt, err_cnt, err_flag, locked}, {14'd0, 32'd2, 16'd1, 1'b1, 1'b0});
    en = 1'b1;
    #1;
    chk("en_rise_erd_en", 64'(erd_en), 64'd1);
    cyc();
    chk("en_rise_clear", {15'd0, good_cnt, err_cnt, err_flag}, 64'd0);
    drain();

    // T6: five errors inside a locked stream; 2-bit counter saturates at 3
    restart();
    feed(P0, mk(1, 0, 0, 0));
    feed(P1, mk(2, 0, 0, 0));
    feed(P2, mk(3, 0, 0, 1));
    for (int k = 0; k < 5; k++) begin
      feed(P0, mk(4 + k, k, k > 0, k == 0));
      feed(P1 ^ (64'h100 << k), mk(4 + k, k + 1, 1, 0));
    end
    drain();
    chk("sat_err_cnt", 64'(s_err_cnt), 64'd3);
    chk("sat_err_flag", 64'(s_err_flag), 64'd1);
    chk("sat_good_cnt", 64'(s_good_cnt), 64'd8);

    // Async reset mid-stream, no clock edge in between
    feed(P0, mk(9, 5, 1, 0));
    feed(P1, mk(10, 5, 1, 0));
    feed(P2, mk(11, 5, 1, 1));
    drain();
    chk("pre_rst_locked", 64'(locked), 64'd1);
    fifo.push_back(P0);
    erx_empty = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_status", {14'd0, good_cnt, err_cnt, err_flag, locked}, 64'd0);
    chk("arst_sat_status", {28'd0, s_good_cnt, s_err_cnt, s_err_flag, s_locked}, 64'd0);
    chk("arst_erd_en", 64'({erd_en, s_erd_en}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
